// File: rtl/osc_pkg.sv
// Shared oscilloscope definitions: scan sequencer states and default sample-RAM geometry.
package osc_pkg;

  localparam int unsigned SCAN_DEPTH_DEF = 256;
  localparam int unsigned ADDR_W_DEF     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_CAP,
    ST_SCAN,
    ST_DRAIN,
    ST_LATCH,
    ST_HOLD
  } scan_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scan_delay_line.sv
// LAT-stage shift register with synchronous clear; aligns a strobe to RAM read latency.
module scan_delay_line #(
  parameter int unsigned LAT = 1
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  if (LAT == 0) begin : g_pass
    logic w_unused;
    assign w_unused = i_clk ^ i_clr;
    assign o_q      = i_d;
  end else begin : g_pipe
    logic [LAT-1:0] r_sh;

    always_ff @(posedge i_clk) begin
      if (i_clr) begin
        r_sh <= '0;
      end else begin
        r_sh[0] <= i_d;
        for (int unsigned i = 1; i < LAT; i++) begin
          r_sh[i] <= r_sh[i-1];
        end
      end
    end

    assign o_q = r_sh[LAT-1];
  end

endmodule

// File: rtl/vpp_scan_ctrl.sv
// Vpp measurement sequencer: capture request, sequential RAM scan with latency-aligned
// data_en, max/min latch gap, and display refresh pacing.
module vpp_scan_ctrl
  import osc_pkg::*;
#(
  parameter int unsigned AW          = ADDR_W_DEF,
  parameter int unsigned DEPTH       = SCAN_DEPTH_DEF,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned REFRESH_CYC = 1000000,
  parameter int unsigned CAP_TIMEOUT = 65535
) (
  input  logic          clk_scan,
  input  logic          rst_scan,
  input  logic          run_en,
  input  logic          single,
  output logic          cap_req,
  input  logic          cap_done,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_rd_addr,
  output logic          data_en,
  output logic          meas_valid,
  output logic          busy,
  output logic          cap_err
);

  // One counter serves WAIT_CAP, DRAIN and LATCH, so it is sized for the largest of them.
  localparam int unsigned CW = $clog2(max_u(max_u(CAP_TIMEOUT, GAP_CYC), RD_LAT) + 1);
  localparam int unsigned RW = $clog2(REFRESH_CYC + 1);

  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(CAP_TIMEOUT - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'((RD_LAT > 0) ? RD_LAT - 1 : 0);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_CYC - 1);

  scan_state_t   r_state;
  scan_state_t   w_nxt;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_ref;
  logic          r_cap_err;

  logic w_tmo;
  logic w_cap_req;
  logic w_rd_en;
  logic w_meas_valid;
  logic w_data_en;

  assign w_tmo = (r_cnt == TMO_LAST);

  always_comb begin
    w_nxt        = r_state;
    w_cap_req    = 1'b0;
    w_rd_en      = 1'b0;
    w_meas_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run_en || single) w_nxt = ST_ARM;
      end
      ST_ARM: begin
        w_cap_req = 1'b1;
        w_nxt     = ST_WAIT_CAP;
      end
      ST_WAIT_CAP: begin
        if (cap_done)   w_nxt = ST_SCAN;
        else if (w_tmo) w_nxt = ST_IDLE;
      end
      ST_SCAN: begin
        w_rd_en = 1'b1;
        if (r_addr == LAST_ADDR) w_nxt = (RD_LAT == 0) ? ST_LATCH : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_cnt == DRAIN_LAST) w_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        if (r_cnt == GAP_LAST) begin
          w_meas_valid = 1'b1;
          w_nxt        = run_en ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!run_en)                w_nxt = ST_IDLE;
        else if (r_ref == REF_LAST) w_nxt = ST_ARM;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_scan) begin
    if (rst_scan) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_ref     <= '0;
      r_cap_err <= 1'b0;
    end else begin
      r_state <= w_nxt;

      if (w_nxt != r_state) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT_CAP || r_state == ST_DRAIN || r_state == ST_LATCH) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == ST_HOLD && w_nxt == ST_HOLD) r_ref <= r_ref + 1'b1;
      else                                        r_ref <= '0;

      // Address returns to zero on the last read, so it never wraps within a frame.
      if (r_state == ST_SCAN && w_nxt == ST_SCAN) r_addr <= r_addr + 1'b1;
      else                                        r_addr <= '0;

      if (r_state == ST_ARM) begin
        r_cap_err <= 1'b0;
      end else if (r_state == ST_WAIT_CAP && !cap_done && w_tmo) begin
        r_cap_err <= 1'b1;
      end
    end
  end

  scan_delay_line #(
    .LAT (RD_LAT)
  ) u_dly (
    .i_clk (clk_scan),
    .i_clr (rst_scan),
    .i_d   (w_rd_en),
    .o_q   (w_data_en)
  );

  assign cap_req     = w_cap_req;
  assign ram_rd_en   = w_rd_en;
  assign ram_rd_addr = r_addr;
  assign data_en     = w_data_en;
  assign meas_valid  = w_meas_valid;
  assign busy        = (r_state != ST_IDLE);
  assign cap_err     = r_cap_err;

endmodule

// File: tb/tb_vpp_scan_ctrl.sv
// Bench for vpp_scan_ctrl: three parameterisations driven together, a frame-timeline
// reference model checked every cycle, a vector table and directed corner sequences.
module tb_vpp_scan_ctrl;

  localparam int unsigned DONE_LAT = 10;
  localparam int unsigned PD [3] = '{256, 16, 16};
  localparam int unsigned PL [3] = '{1, 0, 3};
  localparam int unsigned PG [3] = '{2, 2, 3};
  localparam int unsigned PR = 20;
  localparam int unsigned PT = 50;

  logic       clk_scan = 1'b0;
  logic       rst_scan = 1'b1;
  logic       run_en   = 1'b0;
  logic       single   = 1'b0;
  logic [2:0] cap_done = '0;
  logic [2:0] cap_req, ram_rd_en, data_en, meas_valid, busy, cap_err;
  logic [7:0] addr0;
  logic [3:0] addr1, addr2;

  int n_chk  = 0;
  int n_fail = 0;

  vpp_scan_ctrl #(.AW(8), .DEPTH(256), .RD_LAT(1), .GAP_CYC(2), .REFRESH_CYC(PR), .CAP_TIMEOUT(PT)) u_dut0 (
    .clk_scan(clk_scan), .rst_scan(rst_scan), .run_en(run_en), .single(single),
    .cap_req(cap_req[0]), .cap_done(cap_done[0]), .ram_rd_en(ram_rd_en[0]), .ram_rd_addr(addr0),
    .data_en(data_en[0]), .meas_valid(meas_valid[0]), .busy(busy[0]), .cap_err(cap_err[0]));

  vpp_scan_ctrl #(.AW(4), .DEPTH(16), .RD_LAT(0), .GAP_CYC(2), .REFRESH_CYC(PR), .CAP_TIMEOUT(PT)) u_dut1 (
    .clk_scan(clk_scan), .rst_scan(rst_scan), .run_en(run_en), .single(single),
    .cap_req(cap_req[1]), .cap_done(cap_done[1]), .ram_rd_en(ram_rd_en[1]), .ram_rd_addr(addr1),
    .data_en(data_en[1]), .meas_valid(meas_valid[1]), .busy(busy[1]), .cap_err(cap_err[1]));

  vpp_scan_ctrl #(.AW(4), .DEPTH(16), .RD_LAT(3), .GAP_CYC(3), .REFRESH_CYC(PR), .CAP_TIMEOUT(PT)) u_dut2 (
    .clk_scan(clk_scan), .rst_scan(rst_scan), .run_en(run_en), .single(single),
    .cap_req(cap_req[2]), .cap_done(cap_done[2]), .ram_rd_en(ram_rd_en[2]), .ram_rd_addr(addr2),
    .data_en(data_en[2]), .meas_valid(meas_valid[2]), .busy(busy[2]), .cap_err(cap_err[2]));

  always #5 clk_scan = ~clk_scan;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-timeline model: phase 0 idle, 1 armed/waiting, 2 after cap_done, 3 refresh hold.
  int     ph [3] = '{0, 0, 0};
  longint ts [3], td [3], th [3];
  bit     err [3] = '{0, 0, 0};
  longint cyc = 0;
  bit     mon_on = 1'b0;

  function automatic logic [13:0] model_out(input int i);
    logic cr, rd, de, mv, bz;
    logic [7:0] ad;
    longint k;
    cr = 1'b0; rd = 1'b0; de = 1'b0; mv = 1'b0; ad = 8'd0;
    bz = (ph[i] != 0);
    if (ph[i] == 1) cr = (cyc == ts[i]);
    if (ph[i] == 2) begin
      k  = cyc - td[i];
      rd = (k >= 1) && (k <= longint'(PD[i]));
      ad = rd ? 8'(k - 1) : 8'd0;
      de = (k >= longint'(PL[i]) + 1) && (k <= longint'(PL[i] + PD[i]));
      mv = (k == longint'(PD[i] + PL[i] + PG[i]));
    end
    return {cr, rd, ad, de, mv, bz, err[i]};
  endfunction

  function automatic void model_step(input int i);
    if (rst_scan) begin
      ph[i] = 0; err[i] = 1'b0;
      return;
    end
    case (ph[i])
      0: if (run_en || single) begin ph[i] = 1; ts[i] = cyc + 1; end
      1: begin
        if (cyc == ts[i]) err[i] = 1'b0;
        else if (cap_done[i]) begin ph[i] = 2; td[i] = cyc; end
        else if (cyc - ts[i] == longint'(PT)) begin err[i] = 1'b1; ph[i] = 0; end
      end
      2: if (cyc - td[i] == longint'(PD[i] + PL[i] + PG[i])) begin
        ph[i] = run_en ? 3 : 0; th[i] = cyc;
      end
      default: begin
        if (!run_en) ph[i] = 0;
        else if (cyc - th[i] == longint'(PR)) begin ph[i] = 1; ts[i] = cyc + 1; end
      end
    endcase
  endfunction

  always @(negedge clk_scan) begin
    logic [13:0] act;
    logic [7:0]  a;
    for (int i = 0; i < 3; i++) begin
      a   = (i == 0) ? addr0 : (i == 1) ? {4'b0, addr1} : {4'b0, addr2};
      act = {cap_req[i], ram_rd_en[i], a, data_en[i], meas_valid[i], busy[i], cap_err[i]};
      if (mon_on) check($sformatf("model_u%0d", i), 64'(act), 64'(model_out(i)));
      model_step(i);
    end
    cyc++;
  end

  // ADC writer stand-in: answers each cap_req DONE_LAT clocks later; spur injects stray pulses.
  int       dcnt [3] = '{0, 0, 0};
  bit       auto_done = 1'b1;
  logic [2:0] spur = '0;

  task automatic tick();
    @(posedge clk_scan);
    #1;
    for (int i = 0; i < 3; i++) begin
      cap_done[i] = 1'b0;
      if (dcnt[i] > 0) begin
        dcnt[i]--;
        if (dcnt[i] == 0) cap_done[i] = 1'b1;
      end
      if (cap_req[i] && auto_done) dcnt[i] = DONE_LAT;
      if (spur[i]) cap_done[i] = 1'b1;
    end
    spur = '0;
  endtask

  task automatic pulse_single();
    single = 1'b1;
    tick();
    single = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n = 0;
    while (busy != 3'b000 && n < lim) begin tick(); n++; end
    check(name, 64'(busy), 64'(3'b000));
  endtask

  typedef struct {
    int         off;
    logic       rd;
    logic [7:0] addr;
    logic       de;
    logic       mv;
    logic       bz;
  } vec_t;

  vec_t tv [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{0,   1'b0, 8'd0,   1'b0, 1'b0, 1'b1};
    tv[1] = '{1,   1'b1, 8'd0,   1'b0, 1'b0, 1'b1};
    tv[2] = '{2,   1'b1, 8'd1,   1'b1, 1'b0, 1'b1};
    tv[3] = '{101, 1'b1, 8'd100, 1'b1, 1'b0, 1'b1};
    tv[4] = '{256, 1'b1, 8'd255, 1'b1, 1'b0, 1'b1};
    tv[5] = '{257, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1};
    tv[6] = '{258, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1};
    tv[7] = '{259, 1'b0, 8'd0,   1'b0, 1'b1, 1'b1};
    tv[8] = '{260, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0};

    tick();
    mon_on = 1'b1;
    check("reset_outputs", 64'({cap_req, ram_rd_en, data_en, meas_valid, busy, cap_err}), 64'(0));
    tick();
    rst_scan = 1'b0;
    tick();

    // Single frame at default geometry, timed from cap_done.
    begin
      int n = 0;
      int off = 0;
      pulse_single();
      while (!cap_done[0] && n < 100) begin tick(); n++; end
      check("t1_cap_done_seen", 64'(cap_done[0]), 64'(1));
      foreach (tv[j]) begin
        while (off < tv[j].off) begin tick(); off++; end
        check($sformatf("t1_off%0d", tv[j].off),
              64'({ram_rd_en[0], addr0, data_en[0], meas_valid[0], busy[0]}),
              64'({tv[j].rd, tv[j].addr, tv[j].de, tv[j].mv, tv[j].bz}));
      end
      wait_idle("t1_idle", 500);
    end

    // Free-running frames: period = DONE_LAT + DEPTH + RD_LAT + GAP_CYC + REFRESH_CYC + 1.
    begin
      longint t [3];
      int k = 0, n = 0, mvc = 0, crc = 0;
      run_en = 1'b1;
      while (k < 3 && n < 2000) begin
        tick(); n++;
        if (cap_req[0]) begin t[k] = n; k++; end
      end
      check("t2_frames", 64'(k), 64'(3));
      check("t2_period1", 64'(t[1] - t[0]), 64'(290));
      check("t2_period2", 64'(t[2] - t[1]), 64'(290));
      n = 0;
      while (!(ram_rd_en[0] && addr0 == 8'd50) && n < 400) begin tick(); n++; end
      check("t2_mid_scan", 64'(addr0), 64'(50));
      run_en = 1'b0;
      for (int c = 0; c < 600; c++) begin
        tick();
        if (meas_valid[0]) mvc++;
        if (cap_req[0]) crc++;
      end
      check("t2_last_meas", 64'(mvc), 64'(1));
      check("t2_no_more_req", 64'(crc), 64'(0));
      wait_idle("t2_idle", 200);
    end

    // Capture timeout, then recovery clears cap_err with the next cap_req.
    auto_done = 1'b0;
    pulse_single();
    check("t3_arm", 64'(cap_req), 64'(3'b111));
    repeat (PT) tick();
    check("t3_err_before", 64'({cap_err, busy}), 64'({3'b000, 3'b111}));
    tick();
    check("t3_err_set", 64'({cap_err, busy, ram_rd_en}), 64'({3'b111, 3'b000, 3'b000}));
    auto_done = 1'b1;
    pulse_single();
    check("t3_err_held_arm", 64'({cap_req, cap_err}), 64'({3'b111, 3'b111}));
    tick();
    check("t3_err_cleared", 64'(cap_err), 64'(3'b000));
    wait_idle("t3_idle", 1000);

    // Read-latency alignment of data_en against ram_rd_en.
    begin
      int rf [3] = '{-1, -1, -1};
      int df [3] = '{-1, -1, -1};
      int dc [3] = '{0, 0, 0};
      pulse_single();
      for (int n = 0; n < 400; n++) begin
        tick();
        for (int i = 0; i < 3; i++) begin
          if (ram_rd_en[i] && rf[i] < 0) rf[i] = n;
          if (data_en[i] && df[i] < 0) df[i] = n;
          if (data_en[i]) dc[i]++;
        end
      end
      check("t4_lat0_offset", 64'(df[1] - rf[1]), 64'(0));
      check("t4_lat3_offset", 64'(df[2] - rf[2]), 64'(3));
      check("t4_lat0_count", 64'(dc[1]), 64'(16));
      check("t4_lat3_count", 64'(dc[2]), 64'(16));
      check("t4_lat1_count", 64'(dc[0]), 64'(256));
      wait_idle("t4_idle", 100);
    end

    // Reset mid-scan aborts without meas_valid; next single starts at address 0.
    begin
      int n = 0, mvc = 0;
      pulse_single();
      while (!(ram_rd_en[0] && addr0 == 8'd100) && n < 400) begin tick(); n++; end
      check("t5_at_addr100", 64'(addr0), 64'(100));
      rst_scan = 1'b1;
      dcnt = '{0, 0, 0};
      tick();
      rst_scan = 1'b0;
      check("t5_outputs_zero",
            64'({cap_req[0], ram_rd_en[0], addr0, data_en[0], meas_valid[0], busy, cap_err[0]}), 64'(0));
      for (int c = 0; c < 50; c++) begin tick(); if (meas_valid[0]) mvc++; end
      check("t5_no_meas", 64'(mvc), 64'(0));
      pulse_single();
      n = 0;
      while (!ram_rd_en[0] && n < 100) begin tick(); n++; end
      check("t5_restart_addr", 64'({ram_rd_en[0], addr0}), 64'({1'b1, 8'd0}));
      wait_idle("t5_idle", 400);
    end

    // Stray cap_done in SCAN and HOLD, single while busy.
    begin
      int n = 0, crc = 0;
      run_en = 1'b1;
      while (!meas_valid[0] && n < 600) begin
        tick(); n++;
        single = 1'b0;
        if (cap_req[0]) crc++;
        if (ram_rd_en[0] && addr0 == 8'd20) spur = 3'b111;
        if (ram_rd_en[0] && addr0 == 8'd40) single = 1'b1;
      end
      single = 1'b0;
      check("t6_meas_seen", 64'(meas_valid[0]), 64'(1));
      check("t6_one_req", 64'(crc), 64'(1));
      spur = 3'b111;
      tick();
      repeat (3) tick();
      check("t6_hold_undisturbed", 64'({busy[0], cap_req[0]}), 64'({1'b1, 1'b0}));
      run_en = 1'b0;
      tick();
      check("t6_hold_exit", 64'(busy[0]), 64'(0));
      wait_idle("t6_idle", 400);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
